// File: rtl/vpu_int_pipe.sv
// vpu_int_pipe
//   Pipelined integer vector unit for the EX stage. Lane-wise masked ALU ops,
//   masked lane compares that pack one flag per lane into rd, and masked
//   reductions (sum / signed max) that walk one lane per clock.
//   Two stages: S1 holds the accepted operation, S2 is the output register.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous flush, drops S1, S2 and any reduction in progress
//   in_valid   operation present on op/vs1/vs2/mask
//   in_ready   unit accepts the operation this cycle
//   op         4-bit opcode (see OP_* below)
//   vs1, vs2   source vectors, lane i = bits [LW*i+LW-1:LW*i]
//   mask       per-lane enable
//   out_valid  vd/rd hold a result
//   out_ready  consumer takes the result
//   vd         vector result
//   rd         scalar result (compare flags or reduction value)
module vpu_int_pipe #(
  parameter int LANES = 8,
  parameter int LW    = 16,
  parameter int RW    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          op,
  input  logic [LANES*LW-1:0] vs1,
  input  logic [LANES*LW-1:0] vs2,
  input  logic [LANES-1:0]    mask,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*LW-1:0] vd,
  output logic [RW-1:0]       rd
);
  localparam int SW = $clog2(LW);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MAX  = 4'd5;
  localparam logic [3:0] OP_MIN  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_CGE  = 4'd10;
  localparam logic [3:0] OP_CLT  = 4'd11;
  localparam logic [3:0] OP_CEQ  = 4'd12;
  localparam logic [3:0] OP_CNE  = 4'd13;
  localparam logic [3:0] OP_RSUM = 4'd14;
  localparam logic [3:0] OP_RMAX = 4'd15;

  localparam logic signed [RW-1:0] MOST_NEG = {1'b1, {(RW-1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RED, ST_DONE} state_t;

  state_t                 state, state_next;
  logic                   s1_full;
  logic [3:0]             s1_op;
  logic [LANES*LW-1:0]    s1_vs1, s1_vs2;
  logic [LANES-1:0]       s1_mask;
  logic [IW-1:0]          red_idx;
  logic signed [RW-1:0]   acc;
  logic                   acc_flag;

  logic                   s2_free, lane_adv, red_adv, s1_adv, accept;
  logic                   in_is_red, s1_is_red, red_last;
  logic [LW-1:0]          red_lanes [LANES];
  logic signed [LW-1:0]   red_lane;
  logic signed [RW-1:0]   red_sext;
  logic [LANES-1:0]       cmp_flags;
  logic [LANES*LW-1:0]    res_vd;
  logic [RW-1:0]          res_rd;

  assign in_is_red = (op == OP_RSUM) || (op == OP_RMAX);
  assign s1_is_red = (s1_op == OP_RSUM) || (s1_op == OP_RMAX);
  assign s2_free   = !out_valid || out_ready;

  // Lane/compare ops leave S1 straight away; a reduction only leaves from DONE.
  assign lane_adv = s1_full && !s1_is_red && (state == ST_IDLE) && s2_free;
  assign red_adv  = (state == ST_DONE) && s2_free;
  assign s1_adv   = !flush && (lane_adv || red_adv);
  assign in_ready = !flush && (!s1_full || s1_adv);
  assign accept   = in_valid && in_ready;

  // Per-lane datapath on the S1 contents.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LW-1:0] a, b, r;
    logic [SW-1:0] sh;
    logic          flag;

    assign a  = s1_vs1[LW*gi +: LW];
    assign b  = s1_vs2[LW*gi +: LW];
    assign sh = b[SW-1:0];
    assign red_lanes[gi] = a;

    always_comb begin
      r    = a;
      flag = 1'b0;
      case (s1_op)
        OP_ADD:  r = a + b;
        OP_SUB:  r = a - b;
        OP_AND:  r = a & b;
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_MAX:  r = ($signed(a) > $signed(b)) ? a : b;
        OP_MIN:  r = ($signed(a) < $signed(b)) ? a : b;
        OP_SLL:  r = a << sh;
        OP_SRL:  r = a >> sh;
        OP_SRA:  r = $signed(a) >>> sh;
        OP_CGE:  flag = ($signed(a) >= $signed(b));
        OP_CLT:  flag = ($signed(a) <  $signed(b));
        OP_CEQ:  flag = (a == b);
        OP_CNE:  flag = (a != b);
        default: ;
      endcase
    end

    assign cmp_flags[gi] = flag & s1_mask[gi];
    // Compares and reductions pass vs1 through; masked-off lanes keep vs1.
    assign res_vd[LW*gi +: LW] = ((s1_op <= OP_SRA) && s1_mask[gi]) ? r : a;
  end

  assign red_lane = red_lanes[red_idx];
  assign red_sext = RW'(red_lane);
  assign red_last = (red_idx == IW'(LANES - 1));

  always_comb begin
    res_rd = '0;
    if (s1_op == OP_RSUM)
      res_rd = acc;
    else if (s1_op == OP_RMAX)
      res_rd = acc_flag ? acc : '0;  // no enabled lane -> 0
    else if (s1_op >= OP_CGE)
      res_rd = RW'(cmp_flags);
  end

  // Reduction sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RED:  if (red_last) state_next = ST_DONE;
      ST_DONE: if (s2_free)  state_next = ST_IDLE;
      default: ;
    endcase
    // A reduction enters RED the moment it lands in S1, which can coincide
    // with the previous reduction leaving DONE.
    if (accept && in_is_red) state_next = ST_RED;
    if (flush)               state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      red_idx  <= '0;
      acc      <= '0;
      acc_flag <= 1'b0;
    end else if (flush) begin
      red_idx  <= '0;
      acc      <= '0;
      acc_flag <= 1'b0;
    end else if (accept && in_is_red) begin
      red_idx  <= '0;
      acc      <= (op == OP_RMAX) ? MOST_NEG : '0;
      acc_flag <= 1'b0;
    end else if (state == ST_RED) begin
      if (!red_last) red_idx <= red_idx + 1'b1;
      if (s1_mask[red_idx]) begin
        if (s1_op == OP_RSUM) begin
          acc <= acc + red_sext;
        end else if (!acc_flag || (red_sext > acc)) begin
          acc      <= red_sext;
          acc_flag <= 1'b1;
        end
      end
    end
  end

  // S1 input register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_full <= 1'b0;
      s1_op   <= '0;
      s1_vs1  <= '0;
      s1_vs2  <= '0;
      s1_mask <= '0;
    end else if (flush) begin
      s1_full <= 1'b0;
    end else if (accept) begin
      s1_full <= 1'b1;
      s1_op   <= op;
      s1_vs1  <= vs1;
      s1_vs2  <= vs2;
      s1_mask <= mask;
    end else if (s1_adv) begin
      s1_full <= 1'b0;
    end
  end

  // S2 output register; reloads in the same cycle the old result is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      vd        <= '0;
      rd        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      vd        <= '0;
      rd        <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      vd        <= res_vd;
      rd        <= res_rd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vpu_int_pipe.sv
// Testbench for vpu_int_pipe: directed cases with literal expectations plus a
// randomized run scored against a lane-by-lane integer model and an in-order
// queue of expected results.
module tb_vpu_int_pipe;
  localparam int LANES = 8;
  localparam int LW    = 16;
  localparam int RW    = 32;
  localparam int VW    = LANES * LW;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       op = '0;
  logic [VW-1:0]    vs1 = '0;
  logic [VW-1:0]    vs2 = '0;
  logic [LANES-1:0] mask = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [VW-1:0]    vd;
  logic [RW-1:0]    rd;

  vpu_int_pipe #(.LANES(LANES), .LW(LW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .vs1(vs1), .vs2(vs2), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .vd(vd), .rd(rd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [VW-1:0] vd;
    logic [RW-1:0] rd;
  } exp_t;
  exp_t q[$];

  logic          hold_prev = 1'b0;
  logic [VW-1:0] hold_vd;
  logic [RW-1:0] hold_rd;

  task automatic chk_v(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_r(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", nm, act, exp);
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference: each lane as a plain integer, signed view by subtracting 2^LW.
  function automatic void model(input logic [3:0] o, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                input logic [LANES-1:0] m,
                                output logic [VW-1:0] vd_e, output logic [RW-1:0] rd_e);
    int sum, best;
    bit found;
    vd_e = a; rd_e = '0; sum = 0; best = 0; found = 0;
    for (int i = 0; i < LANES; i++) begin
      int ua, ub, sa, sb, sh, r;
      bit f;
      ua = int'(a[i*LW +: LW]);
      ub = int'(b[i*LW +: LW]);
      sa = (ua >= (1 << (LW-1))) ? ua - (1 << LW) : ua;
      sb = (ub >= (1 << (LW-1))) ? ub - (1 << LW) : ub;
      sh = ub % LW;
      r = ua; f = 0;
      case (o)
        4'd0:  r = ua + ub;
        4'd1:  r = ua - ub;
        4'd2:  r = ua & ub;
        4'd3:  r = ua | ub;
        4'd4:  r = ua ^ ub;
        4'd5:  r = (sa > sb) ? sa : sb;
        4'd6:  r = (sa < sb) ? sa : sb;
        4'd7:  r = ua << sh;
        4'd8:  r = ua >> sh;
        4'd9:  r = sa >>> sh;
        4'd10: f = (sa >= sb);
        4'd11: f = (sa < sb);
        4'd12: f = (sa == sb);
        4'd13: f = (sa != sb);
        default: ;
      endcase
      if (o <= 4'd9 && m[i]) vd_e[i*LW +: LW] = r[LW-1:0];
      if (f && m[i]) rd_e[i] = 1'b1;
      if (m[i]) begin
        sum += sa;
        if (!found || sa > best) begin best = sa; found = 1; end
      end
    end
    if (o == 4'd14) rd_e = sum;
    if (o == 4'd15) rd_e = found ? best : 0;
  endfunction

  // Compare process: scoreboard every negedge.
  always @(negedge clk) begin
    logic [VW-1:0] ev;
    logic [RW-1:0] er;
    exp_t e;
    if (!rst) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk_b("hold_valid", out_valid, 1'b1);
        chk_v("hold_vd", vd, hold_vd);
        chk_r("hold_rd", rd, hold_rd);
      end
      if (out_valid && out_ready && !flush) begin
        if (q.size() == 0) begin
          chk_i("sb_spurious_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk_v("sb_vd", vd, e.vd);
          chk_r("sb_rd", rd, e.rd);
        end
      end
      if (in_valid && in_ready) begin
        model(op, vs1, vs2, mask, ev, er);
        e.vd = ev;
        e.rd = er;
        q.push_back(e);
      end
      if (flush) begin
        q.delete();
        hold_prev = 1'b0;
      end else begin
        hold_prev = out_valid && !out_ready;
        hold_vd   = vd;
        hold_rd   = rd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] o, input logic [VW-1:0] a,
                       input logic [VW-1:0] b, input logic [LANES-1:0] m);
    in_valid = v; op = o; vs1 = a; vs2 = b; mask = m;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) tick();
  endtask

  // One lane/compare op into an empty pipe; result must appear 2 cycles later.
  task automatic issue_lane(input string nm, input logic [3:0] o, input logic [VW-1:0] a,
                            input logic [VW-1:0] b, input logic [LANES-1:0] m,
                            input logic [VW-1:0] ev, input logic [RW-1:0] er);
    out_ready = 1'b1;
    drive(1'b1, o, a, b, m);
    @(negedge clk); chk_b({nm, "_accept"}, in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    @(negedge clk); chk_b({nm, "_lat1"}, out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk_b({nm, "_valid"}, out_valid, 1'b1);
    chk_v({nm, "_vd"}, vd, ev);
    chk_r({nm, "_rd"}, rd, er);
    tick();
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*LW +: LW] = 16'h0000;
        1:       v[i*LW +: LW] = 16'h7FFF;
        2:       v[i*LW +: LW] = 16'h8000;
        3:       v[i*LW +: LW] = 16'hFFFF;
        default: v[i*LW +: LW] = 16'($urandom);
      endcase
    end
    return v;
  endfunction

  function automatic logic [LANES-1:0] rand_mask();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return LANES'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] mv, held_vd, t3_vs1;
    logic [RW-1:0] mr;
    logic [15:0]   lv;
    bit            early, ir_bad, seen, pending;
    int            k, wait_n;

    t3_vs1 = {16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'hFFFF, 16'h0007};

    // Pin the model against hand-computed values.
    model(4'd0, {8{16'h7FFF}}, {8{16'h0001}}, 8'hFF, mv, mr);
    chk_v("model_add_vd", mv, {8{16'h8000}});
    chk_r("model_add_rd", mr, 32'h0);
    model(4'd9, {8{16'h8000}}, {8{16'h0004}}, 8'h0F, mv, mr);
    chk_v("model_sra_vd", mv, {{4{16'h8000}}, {4{16'hF800}}});
    model(4'd11, t3_vs1, {8{16'h0002}}, 8'hFD, mv, mr);
    chk_r("model_clt_rd", mr, 32'h000000F8);
    model(4'd14, {8{16'hFFFF}}, '0, 8'hFF, mv, mr);
    chk_r("model_rsum_rd", mr, 32'hFFFFFFF8);
    model(4'd15, {8{16'h1234}}, '0, 8'h00, mv, mr);
    chk_r("model_rmax_empty", mr, 32'h0);
    model(4'd15, {{7{16'h0005}}, 16'h8000}, '0, 8'h01, mv, mr);
    chk_r("model_rmax_neg", mr, 32'hFFFF8000);

    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_v("rst_vd", vd, '0);
    chk_r("rst_rd", rd, '0);
    tick(); rst = 1'b1;
    tick();
    @(negedge clk); chk_b("rst_in_ready", in_ready, 1'b1);
    tick();

    issue_lane("t1_add", 4'd0, {8{16'h7FFF}}, {8{16'h0001}}, 8'hFF, {8{16'h8000}}, 32'h0);
    issue_lane("t2_sra", 4'd9, {8{16'h8000}}, {8{16'h0004}}, 8'h0F,
               {{4{16'h8000}}, {4{16'hF800}}}, 32'h0);
    issue_lane("t3_clt", 4'd11, t3_vs1, {8{16'h0002}}, 8'hFD, t3_vs1, 32'h000000F8);

    // RSUM latency: out_valid exactly 10 cycles after accept.
    idle(2);
    drive(1'b1, 4'd14, {8{16'hFFFF}}, '0, 8'hFF);
    @(negedge clk); chk_b("t4_accept", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    early = 0; ir_bad = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (out_valid) early = 1;
      if (c <= 8 && in_ready) ir_bad = 1;
      tick();
    end
    chk_b("t4_no_early_valid", early, 1'b0);
    chk_b("t4_in_ready_low", ir_bad, 1'b0);
    @(negedge clk);
    chk_b("t4_valid_at_10", out_valid, 1'b1);
    chk_r("t4_rsum_rd", rd, 32'hFFFFFFF8);
    chk_v("t4_rsum_vd", vd, {8{16'hFFFF}});
    tick();

    // RMAX with nothing enabled.
    drive(1'b1, 4'd15, {8{16'h4321}}, '0, 8'h00);
    @(negedge clk); tick(); in_valid = 1'b0;
    wait_n = 0;
    while (!out_valid && wait_n < 40) begin tick(); wait_n++; end
    chk_b("t4_rmax_valid", out_valid, 1'b1);
    chk_r("t4_rmax_rd", rd, 32'h0);
    chk_v("t4_rmax_vd", vd, {8{16'h4321}});
    idle(2);

    // Backpressure: 4 ADDs, out_ready low for 5 cycles.
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 5; c++) begin
      lv = 16'(k * 3 + 1);
      drive(1'b1, 4'd0, {8{lv}}, {8{lv}}, 8'hFF);
      @(negedge clk);
      if (in_ready) k++;
      if (c == 2) held_vd = vd;
      if (c == 4) begin
        chk_i("t5_accepts_before_stall", k, 2);
        chk_b("t5_in_ready_low", in_ready, 1'b0);
        chk_b("t5_out_valid_held", out_valid, 1'b1);
        chk_v("t5_vd_stable", vd, held_vd);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && k < 4; c++) begin
      lv = 16'(k * 3 + 1);
      drive(1'b1, 4'd0, {8{lv}}, {8{lv}}, 8'hFF);
      @(negedge clk);
      if (in_ready) k++;
      tick();
    end
    in_valid = 1'b0;
    chk_i("t5_all_accepted", k, 4);
    wait_n = 0;
    while ((q.size() != 0 || out_valid) && wait_n < 40) begin tick(); wait_n++; end
    chk_i("t5_drained", q.size(), 0);
    idle(2);

    // Async reset during a reduction while an ADD result is held in S2.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, {8{16'h1234}}, {8{16'h0001}}, 8'hFF);
    @(negedge clk); tick();
    drive(1'b1, 4'd14, {8{16'h0005}}, '0, 8'hFF);
    @(negedge clk); chk_b("t6_red_accept", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    repeat (3) tick();
    chk_b("t6_held_before_rst", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk_b("t6_rst_out_valid", out_valid, 1'b0);
    chk_v("t6_rst_vd", vd, '0);
    chk_r("t6_rst_rd", rd, '0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_b("t6_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    seen = 0;
    repeat (15) begin tick(); @(negedge clk); if (out_valid) seen = 1; end
    chk_b("t6_no_stale_reduction", seen, 1'b0);
    tick();

    // Flush while S2 is held.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, {8{16'h00AA}}, {8{16'h0011}}, 8'hFF);
    @(negedge clk); tick(); in_valid = 1'b0;
    tick();
    @(negedge clk); chk_b("t6_flush_pre_valid", out_valid, 1'b1);
    tick();
    flush = 1'b1;
    drive(1'b1, 4'd1, {8{16'h0100}}, {8{16'h0001}}, 8'hFF);
    @(negedge clk); chk_b("t6_flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_b("t6_flush_cleared", out_valid, 1'b0);
    @(negedge clk); chk_b("t6_post_flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    seen = 0;
    repeat (4) begin tick(); @(negedge clk); if (out_valid) seen = 1; end
    chk_b("t6_no_phantom", seen, 1'b0);
    tick();

    // Randomized traffic scored by the compare process.
    pending = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!pending) begin
        if ($urandom_range(0, 9) < 7) begin
          drive(1'b1, 4'($urandom_range(0, 15)), rand_vec(), rand_vec(), rand_mask());
          pending = 1;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      if (in_valid && in_ready) pending = 0;
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wait_n = 0;
    while ((q.size() != 0 || out_valid) && wait_n < 100) begin tick(); wait_n++; end
    chk_i("rand_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
